regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised register file with N read ports, one writeback port and a per-register
//  pending-write scoreboard. Issue stage claims a destination (busy set); writeback stage
//  writes data and releases it. Write-to-read bypass and optional hardwired-zero r0.
//  Sits between decode/issue (read + claim) and writeback in the multi-cycle pipeline.
// PARAMETERS
//  LENGTH    32              data width in bits
//  NREGS     32              number of architectural registers (power of 2, >=2)
//  NRD       2               number of read ports (>=1)
//  ZERO_REG  1               1: register 0 reads 0, ignores writes/claims, never busy
//  SEL_BITS  $clog2(NREGS)   address width (derived, do not override)
//  CNT_BITS  $clog2(NREGS+1) busy counter width (derived)
// PORTS
//  clk         input   1              rising-edge clock
//  reset       input   1              asynchronous, active-low reset
//  rd_addr     input   NRD*SEL_BITS   read addresses, port k at [k*SEL_BITS +: SEL_BITS]
//  rd_data     output  NRD*LENGTH     read data, port k at [k*LENGTH +: LENGTH]
//  rd_busy     output  NRD            1 = register read by port k has a pending write
//  wr_en       input   1              writeback strobe
//  wr_addr     input   SEL_BITS       writeback destination
//  wr_data     input   LENGTH         writeback data
//  claim_en    input   1              issue claims claim_addr as pending destination
//  claim_addr  input   SEL_BITS       register to mark busy
//  claim_ok    output  1              claim accepted this cycle (see rules)
//  flush       input   1              clear all busy bits (squash in-flight writes)
//  busy_cnt    output  CNT_BITS       number of registers currently busy
// BEHAVIOUR
//  - Reset (reset=0, async): all regs <= 0, all busy <= 0; busy_cnt=0, claim_ok=0.
//  - Reads combinational, 0-cycle. Bypass: if wr_en & wr_addr==rd_addr[k] (& writable)
//    then rd_data[k]=wr_data, rd_busy[k]=0; else rd_data[k]=reg, rd_busy[k]=busy_q.
//    rd_busy never reflects a same-cycle claim.
//  - Writable: addr!=0 when ZERO_REG=1, else any addr. ZERO_REG=1: rd_data=0, rd_busy=0 for r0.
//  - Write: on clk edge, wr_en & writable -> reg[wr_addr]<=wr_data. Busy cleared for
//    wr_addr unless claimed in the same cycle. Write to non-busy reg is legal (data updated).
//  - Claim: claim_ok = claim_en & ~flush & (~busy_q[claim_addr] | wr_en&wr_addr==claim_addr)
//    for writable addr; claim_en to r0 (ZERO_REG=1): claim_ok=1, no state change.
//    claim_ok=1 -> busy[claim_addr]<=1 at edge. claim_ok=0 (WAW) -> no state change;
//    issue must stall and retry.
//  - Same cycle write+claim same addr: data written, busy stays 1 (new owner wins).
//  - flush=1: all busy<=0 at edge; same-cycle claim rejected; same-cycle write still
//    updates data.
//  - busy_cnt: registered popcount of busy_q, updated with busy (0..NREGS, no wrap).
//  - Reset asserted mid-operation overrides write/claim/flush immediately.
// TESTING
//  1. Reset, write r5=0xDEADBEEF, next cycle read port0=r5 -> 0xDEADBEEF, rd_busy=0.
//  2. Claim r3 -> claim_ok=1, next cycle rd_busy(r3)=1, busy_cnt=1; write r3=0x12 ->
//     same-cycle read gives 0x12/busy 0; next cycle busy_cnt=0.
//  3. Claim r3 twice (no writeback) -> 2nd claim_ok=0, busy_cnt stays 1.
//  4. r3 busy; write r3=0x7 + claim r3 same cycle -> claim_ok=1, r3=0x7, still busy.
//  5. ZERO_REG=1: write r0=0xFFFF, claim r0 -> reads 0, rd_busy=0, busy_cnt=0.
//  6. Claim r1,r2,r4 then flush+claim r6 -> claim_ok=0, busy_cnt=0 next cycle; reset
//     pulsed mid-sequence zeroes all regs asynchronously.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with N read ports, writeback bypass and pending-write scoreboard
module regfile_scoreboard #(
  parameter int LENGTH   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int SEL_BITS = $clog2(NREGS),
  parameter int CNT_BITS = $clog2(NREGS + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [NRD*SEL_BITS-1:0] rd_addr_i,
  output logic [NRD*LENGTH-1:0]   rd_data_o,
  output logic [NRD-1:0]          rd_busy_o,
  input  logic                    wr_en_i,
  input  logic [SEL_BITS-1:0]     wr_addr_i,
  input  logic [LENGTH-1:0]       wr_data_i,
  input  logic                    claim_en_i,
  input  logic [SEL_BITS-1:0]     claim_addr_i,
  output logic                    claim_ok_o,
  input  logic                    flush_i,
  output logic [CNT_BITS-1:0]     busy_cnt_o
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [LENGTH-1:0]   regs_q [NREGS];
  logic [NREGS-1:0]    busy_q, busy_d;
  logic [CNT_BITS-1:0] busy_cnt_q, busy_cnt_d;

  logic wr_ok;
  logic claim_is_zero;
  logic claim_set;

  // r0 is a constant when hardwired: writes to it are dropped, claims are no-ops
  assign wr_ok         = wr_en_i && !(HAS_ZERO && (wr_addr_i == '0));
  assign claim_is_zero = HAS_ZERO && (claim_addr_i == '0);

  // A claim is granted if the register is free or its owner retires this very cycle
  assign claim_ok_o = reset_ni && claim_en_i && !flush_i &&
                      (claim_is_zero || !busy_q[claim_addr_i] ||
                       (wr_ok && (wr_addr_i == claim_addr_i)));
  assign claim_set  = claim_ok_o && !claim_is_zero;

  // Next busy vector: writeback releases, a granted claim re-arms (new owner wins), flush clears all
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)     busy_d[wr_addr_i]    = 1'b0;
    if (claim_set) busy_d[claim_addr_i] = 1'b1;
    if (flush_i)   busy_d = '0;
    busy_cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_BITS'(busy_d[i]);
    end
  end

  // Scoreboard state and its population count, kept in step
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Register storage; flush does not squash data, only ownership
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Combinational read ports with writeback bypass; a same-cycle claim is never visible here
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      if (HAS_ZERO && (rd_addr_i[k*SEL_BITS +: SEL_BITS] == '0)) begin
        rd_data_o[k*LENGTH +: LENGTH] = '0;
        rd_busy_o[k]                  = 1'b0;
      end else if (wr_ok && (wr_addr_i == rd_addr_i[k*SEL_BITS +: SEL_BITS])) begin
        rd_data_o[k*LENGTH +: LENGTH] = wr_data_i;
        rd_busy_o[k]                  = 1'b0;
      end else begin
        rd_data_o[k*LENGTH +: LENGTH] = regs_q[rd_addr_i[k*SEL_BITS +: SEL_BITS]];
        rd_busy_o[k]                  = busy_q[rd_addr_i[k*SEL_BITS +: SEL_BITS]];
      end
    end
  end

  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
  localparam int LENGTH = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int SEL    = 5;
  localparam int CNT    = 6;

  logic              clk = 1'b0;
  logic              reset_ni;
  logic [NRD*SEL-1:0] rd_addr;
  logic [NRD*LENGTH-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [SEL-1:0]    wr_addr;
  logic [LENGTH-1:0] wr_data;
  logic              claim_en;
  logic [SEL-1:0]    claim_addr;
  logic              claim_ok;
  logic              flush;
  logic [CNT-1:0]    busy_cnt;

  int total = 0;
  int bad   = 0;

  // reference state: architectural values and set of registers with an outstanding writer
  logic [LENGTH-1:0] m_reg [NREGS];
  bit                m_busy [NREGS];

  always #5 clk = ~clk;

  regfile_scoreboard #(.LENGTH(LENGTH), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .claim_en_i(claim_en), .claim_addr_i(claim_addr), .claim_ok_o(claim_ok),
    .flush_i(flush), .busy_cnt_o(busy_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  function automatic bit model_claim_ok();
    if (!reset_ni || !claim_en || flush) return 1'b0;
    if (claim_addr == 0) return 1'b1;
    return !m_busy[claim_addr] || (wr_en && wr_addr == claim_addr);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*SEL +: SEL] = SEL'(a);
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NRD; k++) begin
      int a;
      logic [LENGTH-1:0] ed;
      bit eb;
      a = int'(rd_addr[k*SEL +: SEL]);
      if (a == 0) begin ed = '0; eb = 1'b0; end
      else if (wr_en && int'(wr_addr) == a) begin ed = wr_data; eb = 1'b0; end
      else begin ed = m_reg[a]; eb = m_busy[a]; end
      check_eq($sformatf("rd_data%0d[r%0d]", k, a), rd_data[k*LENGTH +: LENGTH], ed);
      check_eq($sformatf("rd_busy%0d[r%0d]", k, a), rd_busy[k], eb);
    end
    check_eq("claim_ok", claim_ok, model_claim_ok());
    check_eq("busy_cnt", busy_cnt, model_count());
  endtask

  // one clock: check outputs mid-cycle, then advance the model with the edge
  task automatic tick();
    bit ok;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    ok = model_claim_ok();
    if (wr_en && wr_addr != 0) begin
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (ok && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    if (flush) for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    #1;
  endtask

  initial begin
    reset_ni = 1'b0;
    idle();
    rd_addr = '0;
    model_reset();
    claim_en = 1'b1; claim_addr = 5'd3;
    #12;
    check_eq("reset_claim_ok", claim_ok, 0);
    check_eq("reset_busy_cnt", busy_cnt, 0);
    check_eq("reset_rd_busy", rd_busy, 0);
    idle();
    @(negedge clk); reset_ni = 1'b1;
    @(posedge clk); #1;

    // write r5, then read it back
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; tick();
    idle(); set_rd(0, 5); #1;
    check_eq("t1_data", rd_data[31:0], 32'hDEADBEEF);
    check_eq("t1_busy", rd_busy[0], 0);
    tick();

    // claim r3, observe busy, retire it with bypass
    claim_en = 1; claim_addr = 3; #1;
    check_eq("t2_claim_ok", claim_ok, 1);
    tick();
    idle(); set_rd(1, 3); #1;
    check_eq("t2_rd_busy", rd_busy[1], 1);
    check_eq("t2_busy_cnt", busy_cnt, 1);
    wr_en = 1; wr_addr = 3; wr_data = 32'h12; #1;
    check_eq("t2_bypass_data", rd_data[63:32], 32'h12);
    check_eq("t2_bypass_busy", rd_busy[1], 0);
    tick();
    idle(); #1;
    check_eq("t2_busy_cnt_after", busy_cnt, 0);

    // WAW: second claim on a busy register is refused
    claim_en = 1; claim_addr = 3; tick();
    #1;
    check_eq("t3_second_claim", claim_ok, 0);
    tick();
    idle(); #1;
    check_eq("t3_busy_cnt", busy_cnt, 1);

    // write and claim same register: new owner keeps it busy
    wr_en = 1; wr_addr = 3; wr_data = 32'h7; claim_en = 1; claim_addr = 3; #1;
    check_eq("t4_claim_ok", claim_ok, 1);
    tick();
    idle(); set_rd(0, 3); #1;
    check_eq("t4_data", rd_data[31:0], 32'h7);
    check_eq("t4_busy", rd_busy[0], 1);
    flush = 1; tick(); idle();

    // hardwired r0
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF; claim_en = 1; claim_addr = 0; set_rd(0, 0); #1;
    check_eq("t5_claim_ok", claim_ok, 1);
    check_eq("t5_bypass_r0", rd_data[31:0], 0);
    tick();
    idle(); #1;
    check_eq("t5_data", rd_data[31:0], 0);
    check_eq("t5_busy", rd_busy[0], 0);
    check_eq("t5_busy_cnt", busy_cnt, 0);

    // several claims, then flush rejects a concurrent claim and clears everything
    claim_en = 1; claim_addr = 1; tick();
    claim_addr = 2; tick();
    claim_addr = 4; tick();
    idle(); #1;
    check_eq("t6_busy_cnt3", busy_cnt, 3);
    flush = 1; claim_en = 1; claim_addr = 6; wr_en = 1; wr_addr = 9; wr_data = 32'hA5A5; #1;
    check_eq("t6_flush_claim", claim_ok, 0);
    tick();
    idle(); set_rd(1, 9); #1;
    check_eq("t6_busy_cnt0", busy_cnt, 0);
    check_eq("t6_flush_write", rd_data[63:32], 32'hA5A5);

    // randomized traffic over a small address window to force collisions
    for (int n = 0; n < 600; n++) begin
      wr_en      = ($urandom % 3) == 0;
      wr_addr    = SEL'($urandom % 8);
      wr_data    = $urandom;
      claim_en   = ($urandom % 2) == 0;
      claim_addr = SEL'($urandom % 8);
      flush      = ($urandom % 20) == 0;
      set_rd(0, $urandom % 8);
      set_rd(1, $urandom % 8);
      tick();
    end

    // reset pulsed between edges wipes data and busy immediately
    idle(); claim_en = 1; claim_addr = 7; tick();
    idle(); set_rd(0, 5); set_rd(1, 7); #2;
    reset_ni = 1'b0; #1;
    model_reset();
    check_eq("async_rst_data", rd_data[31:0], 0);
    check_eq("async_rst_busy", rd_busy, 0);
    check_eq("async_rst_cnt", busy_cnt, 0);
    @(negedge clk); reset_ni = 1'b1;
    @(posedge clk); #1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
